// File: rtl/dl_frame_packer.sv
// Frame packer between the data-link FEC engine and the UART TX FIFO (optional DL_PACKER_PREAMBLE_EN: 0x55 0xD5 sync prefix).
// Latency: CRC starts 1 cycle after start, first byte 1 cycle after the later encoder done; one byte per tx_valid&tx_ready beat.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; start is ignored unless idle.
module dl_frame_packer #(
    parameter int PAYLOAD_BYTES  = 7,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [3:0]                 frm_type,
    input  logic [7:0]                 msg_len,
    input  logic [3:0]                 msg_tag,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic [8*PAYLOAD_BYTES-1:0] fec_data,
    output logic [7:0]                 fec_msg_len,
    output logic [3:0]                 fec_msg_tag,
    output logic                       crc0_start,
    output logic                       crc1_start,
    input  logic                       enc0_done,
    input  logic [7:0]                 crc0_data,
    input  logic [7:0]                 enc0_row_p,
    input  logic [7:0]                 enc0_col_p,
    input  logic                       enc1_done,
    input  logic [3:0]                 crc1_data,
    input  logic [3:0]                 enc1_row_p,
    input  logic [3:0]                 enc1_col_p,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

`ifdef DL_PACKER_PREAMBLE_EN
    localparam int PRE_BYTES = 2;
`else
    localparam int PRE_BYTES = 0;
`endif
    localparam int FRAME_BYTES = PRE_BYTES + PAYLOAD_BYTES + 7;
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [3:0]             type_q;
    logic [IDX_W-1:0]       idx_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   d0_q, d1_q;
    logic [7:0]             crc0_q, rp0_q, cp0_q;
    logic [3:0]             crc1_q, rp1_q, cp1_q;
    logic                   both_done;
    logic [7:0]             frame_b [FRAME_BYTES];

    // Flags raised this cycle count, so SEND follows the later done pulse directly.
    assign both_done = (d0_q | enc0_done) & (d1_q | enc1_done);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        crc0_start = 1'b0;
        crc1_start = 1'b0;
        tx_valid   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_KICK;
                end
            end
            S_KICK: begin
                crc0_start = 1'b1;
                crc1_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (both_done) begin
                    state_d = S_SEND;
                end else if (to_cnt_q == TO_LAST) begin
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready && idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            type_q      <= '0;
            fec_data    <= '0;
            fec_msg_len <= '0;
            fec_msg_tag <= '0;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            d0_q        <= 1'b0;
            d1_q        <= 1'b0;
            crc0_q      <= '0;
            rp0_q       <= '0;
            cp0_q       <= '0;
            crc1_q      <= '0;
            rp1_q       <= '0;
            cp1_q       <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                type_q      <= frm_type;
                fec_data    <= payload;
                fec_msg_len <= msg_len;
                fec_msg_tag <= msg_tag;
            end
            if (state_q == S_KICK) begin
                d0_q     <= 1'b0;
                d1_q     <= 1'b0;
                to_cnt_q <= '0;
                idx_q    <= '0;
            end
            if (state_q == S_WAIT) begin
                to_cnt_q <= to_cnt_q + 1'b1;
                if (enc0_done) begin
                    d0_q   <= 1'b1;
                    crc0_q <= crc0_data;
                    rp0_q  <= enc0_row_p;
                    cp0_q  <= enc0_col_p;
                end
                if (enc1_done) begin
                    d1_q   <= 1'b1;
                    crc1_q <= crc1_data;
                    rp1_q  <= enc1_row_p;
                    cp1_q  <= enc1_col_p;
                end
            end
            if (state_q == S_SEND && tx_ready) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Byte map of the outgoing frame, indexed by the send pointer.
    always_comb begin
        for (int i = 0; i < FRAME_BYTES; i++) begin
            frame_b[i] = 8'h00;
        end
`ifdef DL_PACKER_PREAMBLE_EN
        frame_b[0] = 8'h55;
        frame_b[1] = 8'hD5;
`endif
        frame_b[PRE_BYTES + 0] = {type_q, fec_msg_tag};
        frame_b[PRE_BYTES + 1] = fec_msg_len;
        frame_b[PRE_BYTES + 2] = {crc1_q, rp1_q};
        frame_b[PRE_BYTES + 3] = {cp1_q, 4'h0};
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            frame_b[PRE_BYTES + 4 + i] = fec_data[8*i +: 8];
        end
        frame_b[PRE_BYTES + 4 + PAYLOAD_BYTES] = crc0_q;
        frame_b[PRE_BYTES + 5 + PAYLOAD_BYTES] = rp0_q;
        frame_b[PRE_BYTES + 6 + PAYLOAD_BYTES] = cp0_q;
    end

    assign tx_data = (state_q == S_SEND) ? frame_b[idx_q] : 8'h00;

endmodule

// File: tb/tb_dl_frame_packer.sv
// Randomised bench for dl_frame_packer: an engine model answers the CRC starts, a frame model predicts the byte stream.
module tb_dl_frame_packer;
    localparam int P  = 7;
    localparam int TO = 64;
`ifdef DL_PACKER_PREAMBLE_EN
    localparam int FRAME = P + 9;
`else
    localparam int FRAME = P + 7;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic [3:0] frm_type = '0, msg_tag = '0;
    logic [7:0] msg_len = '0;
    logic [8*P-1:0] payload = '0;
    logic [8*P-1:0] fec_data;
    logic [7:0] fec_msg_len;
    logic [3:0] fec_msg_tag;
    logic crc0_start, crc1_start;
    logic enc0_done = 1'b0, enc1_done = 1'b0;
    logic [7:0] crc0_data = '0, enc0_row_p = '0, enc0_col_p = '0;
    logic [3:0] crc1_data = '0, enc1_row_p = '0, enc1_col_p = '0;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready = 1'b0;
    logic busy, done, err;

    dl_frame_packer #(.PAYLOAD_BYTES(P), .TIMEOUT_CYCLES(TO), .TO_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frm_type(frm_type), .msg_len(msg_len),
        .msg_tag(msg_tag), .payload(payload), .fec_data(fec_data), .fec_msg_len(fec_msg_len),
        .fec_msg_tag(fec_msg_tag), .crc0_start(crc0_start), .crc1_start(crc1_start),
        .enc0_done(enc0_done), .crc0_data(crc0_data), .enc0_row_p(enc0_row_p), .enc0_col_p(enc0_col_p),
        .enc1_done(enc1_done), .crc1_data(crc1_data), .enc1_row_p(enc1_row_p), .enc1_col_p(enc1_col_p),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    // Current message and the engine results the model will hand back.
    logic [3:0] f_type, f_tag;
    logic [7:0] f_len;
    logic [8*P-1:0] f_pay;
    logic [7:0] g_crc0, g_rp0, g_cp0;
    logic [3:0] g_crc1, g_rp1, g_cp1;

    // Observations from the last run_frame call.
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int kick_cyc, first_valid_cyc, last_acc_cyc, err_cyc, done_cyc;
    int acc_cnt, done_cnt, err_cnt, stall_bad, pulse_bad;
    bit timed_out, valid_at_done;

    task automatic new_fields();
        f_type = 4'($urandom);
        f_tag  = 4'($urandom);
        f_len  = 8'($urandom);
        for (int i = 0; i < P; i++) f_pay[8*i +: 8] = 8'($urandom);
        g_crc0 = 8'($urandom); g_rp0 = 8'($urandom); g_cp0 = 8'($urandom);
        g_crc1 = 4'($urandom); g_rp1 = 4'($urandom); g_cp1 = 4'($urandom);
    endtask

    function automatic void build_exp();
        exp_q.delete();
`ifdef DL_PACKER_PREAMBLE_EN
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
`endif
        exp_q.push_back({f_type, f_tag});
        exp_q.push_back(f_len);
        exp_q.push_back({g_crc1, g_rp1});
        exp_q.push_back({g_cp1, 4'h0});
        for (int i = 0; i < P; i++) exp_q.push_back(f_pay[8*i +: 8]);
        exp_q.push_back(g_crc0);
        exp_q.push_back(g_rp0);
        exp_q.push_back(g_cp0);
    endfunction

    // Index of the first stream byte that differs from the model, -1 if identical.
    function automatic int first_bad();
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        return (obs_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    // Drives one message. d0/d1: cycles from KICK to each done pulse (0 = never).
    // rdy_mode: 0 always ready, 1 ready pattern 1,0,0, 2 random. stop_acc >= 0 returns while that byte is presented.
    task automatic run_frame(input int d0, input int d1, input int rdy_mode, input int stop_acc, input bit poke_start);
        bit prev_stall = 1'b0;
        bit finished = 1'b0;
        logic [7:0] prev_data = '0;
        obs_q.delete();
        kick_cyc = -1; first_valid_cyc = -1; last_acc_cyc = -1; err_cyc = -1; done_cyc = -1;
        acc_cnt = 0; done_cnt = 0; err_cnt = 0; stall_bad = 0; pulse_bad = 0; valid_at_done = 1'b0;
        for (int c = 0; c < 400 && !finished; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            frm_type = f_type; msg_tag = f_tag; msg_len = f_len; payload = f_pay;
            if (poke_start && tx_valid && acc_cnt == 3) begin
                start = 1'b1; frm_type = ~f_type; msg_tag = ~f_tag; msg_len = ~f_len; payload = ~f_pay;
            end
            enc0_done = (kick_cyc >= 0 && d0 > 0 && c == kick_cyc + d0);
            enc1_done = (kick_cyc >= 0 && d1 > 0 && c == kick_cyc + d1);
            crc0_data  = enc0_done ? g_crc0 : 8'($urandom);
            enc0_row_p = enc0_done ? g_rp0  : 8'($urandom);
            enc0_col_p = enc0_done ? g_cp0  : 8'($urandom);
            crc1_data  = enc1_done ? g_crc1 : 4'($urandom);
            enc1_row_p = enc1_done ? g_rp1  : 4'($urandom);
            enc1_col_p = enc1_done ? g_cp1  : 4'($urandom);
            case (rdy_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = ((c % 3) == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (crc0_start !== crc1_start) pulse_bad++;
            if (crc0_start === 1'b1) begin
                if (kick_cyc < 0) kick_cyc = c; else pulse_bad++;
            end
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stall_bad++;
            if (stop_acc >= 0 && tx_valid === 1'b1 && acc_cnt == stop_acc) begin
                finished = 1'b1;
            end else begin
                if (tx_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = c;
                if (tx_valid === 1'b1 && tx_ready) begin
                    obs_q.push_back(tx_data); acc_cnt++; last_acc_cyc = c;
                end
                prev_stall = (tx_valid === 1'b1) && !tx_ready;
                prev_data = tx_data;
                if (err === 1'b1) begin err_cnt++; err_cyc = c; finished = 1'b1; end
                if (done === 1'b1) begin done_cnt++; done_cyc = c; valid_at_done = tx_valid; finished = 1'b1; end
            end
        end
        timed_out = !finished;
        start = 1'b0; enc0_done = 1'b0; enc1_done = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if ({tx_valid, busy, done, err, crc0_start, crc1_start} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {tx_valid, busy, done, err, crc0_start, crc1_start});
        end
        n_tests++;
        if ({fec_data, fec_msg_len, fec_msg_tag, tx_data} !== '0) begin
            n_fail++; $display("FAIL reset_data: fec_data=%h len=%h tag=%h tx_data=%h expected all zero", fec_data, fec_msg_len, fec_msg_tag, tx_data);
        end
        rst_n = 1'b0;
    endtask

    task automatic test_basic();
        new_fields();
        f_type = 4'h3; f_tag = 4'hA; f_len = 8'h07;
        for (int i = 0; i < P; i++) f_pay[8*i +: 8] = 8'(i);
        run_frame(10, 4, 0, -1, 1'b0);
        build_exp();
        n_tests++;
        if (timed_out || done_cnt != 1) begin n_fail++; $display("FAIL basic_done: done_cnt=%0d timed_out=%0d expected 1/0", done_cnt, timed_out); end
        n_tests++;
        if (first_bad() != -1) begin n_fail++; $display("FAIL basic_bytes: mismatch at byte %0d, %0d bytes seen, expected %0d", first_bad(), obs_q.size(), exp_q.size()); end
        n_tests++;
        if (kick_cyc != 1 || pulse_bad != 0) begin n_fail++; $display("FAIL basic_kick: kick cycle %0d pulse_bad %0d expected 1/0", kick_cyc, pulse_bad); end
        n_tests++;
        if (first_valid_cyc - kick_cyc != 11) begin n_fail++; $display("FAIL basic_latency: first valid %0d cycles after kick, expected 11", first_valid_cyc - kick_cyc); end
        n_tests++;
        if (last_acc_cyc - first_valid_cyc != FRAME - 1) begin n_fail++; $display("FAIL basic_throughput: span %0d expected %0d", last_acc_cyc - first_valid_cyc, FRAME - 1); end
        n_tests++;
        if (done_cyc != last_acc_cyc + 1 || valid_at_done) begin n_fail++; $display("FAIL basic_done_timing: done at %0d valid=%0d, expected %0d valid=0", done_cyc, valid_at_done, last_acc_cyc + 1); end
        n_tests++;
        if (fec_data !== f_pay || fec_msg_len !== f_len || fec_msg_tag !== f_tag) begin
            n_fail++; $display("FAIL basic_fec: data=%h len=%h tag=%h expected %h %h %h", fec_data, fec_msg_len, fec_msg_tag, f_pay, f_len, f_tag);
        end
    endtask

    task automatic test_done_order();
        int d0s[2] = '{3, 6};
        int d1s[2] = '{8, 6};
        for (int k = 0; k < 2; k++) begin
            new_fields();
            run_frame(d0s[k], d1s[k], 0, -1, 1'b0);
            build_exp();
            n_tests++;
            if (first_bad() != -1 || done_cnt != 1) begin n_fail++; $display("FAIL order%0d_bytes: bad byte %0d done_cnt %0d, expected -1/1", k, first_bad(), done_cnt); end
            n_tests++;
            if (first_valid_cyc - kick_cyc != 9 - 2 * k) begin n_fail++; $display("FAIL order%0d_latency: got %0d expected %0d", k, first_valid_cyc - kick_cyc, 9 - 2 * k); end
        end
    endtask

    task automatic test_backpressure();
        new_fields();
        run_frame(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1, -1, 1'b0);
        build_exp();
        n_tests++;
        if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall: %0d unstable stall cycles, expected 0", stall_bad); end
        n_tests++;
        if (acc_cnt != FRAME || done_cnt != 1) begin n_fail++; $display("FAIL bp_count: accepts %0d done %0d expected %0d/1", acc_cnt, done_cnt, FRAME); end
        n_tests++;
        if (first_bad() != -1) begin n_fail++; $display("FAIL bp_bytes: mismatch at byte %0d", first_bad()); end
    endtask

    task automatic test_timeout();
        new_fields();
        run_frame(5, 0, 0, -1, 1'b0);
        n_tests++;
        if (err_cnt != 1 || err_cyc - kick_cyc != TO) begin n_fail++; $display("FAIL timeout_err: err_cnt %0d at %0d cycles after kick, expected 1 at %0d", err_cnt, err_cyc - kick_cyc, TO); end
        n_tests++;
        if (first_valid_cyc != -1 || done_cnt != 0) begin n_fail++; $display("FAIL timeout_tx: first valid %0d done %0d expected -1/0", first_valid_cyc, done_cnt); end
        @(posedge clk); #2;
        n_tests++;
        if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: busy=%b err=%b expected 0/0", busy, err); end
    endtask

    task automatic test_ignored_start();
        new_fields();
        run_frame(4, 7, 0, -1, 1'b1);
        build_exp();
        n_tests++;
        if (first_bad() != -1 || done_cnt != 1) begin n_fail++; $display("FAIL ignore_bytes: bad byte %0d done %0d expected -1/1", first_bad(), done_cnt); end
        n_tests++;
        if (fec_data !== f_pay || fec_msg_len !== f_len) begin n_fail++; $display("FAIL ignore_fec: data=%h len=%h expected %h %h", fec_data, fec_msg_len, f_pay, f_len); end
    endtask

    task automatic test_reset_mid();
        int late = 0;
        new_fields();
        run_frame(3, 5, 0, 5, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || fec_data !== '0) begin
            n_fail++; $display("FAIL rst_mid_out: valid=%b busy=%b done=%b fec_data=%h expected zeros", tx_valid, busy, done, fec_data);
        end
        repeat (20) begin
            @(posedge clk); #2;
            if (done === 1'b1 || tx_valid === 1'b1 || err === 1'b1) late++;
        end
        n_tests++;
        if (late != 0) begin n_fail++; $display("FAIL rst_mid_quiet: %0d active cycles after reset, expected 0", late); end
        new_fields();
        run_frame(2, 9, 2, -1, 1'b0);
        build_exp();
        n_tests++;
        if (first_bad() != -1 || done_cnt != 1) begin n_fail++; $display("FAIL rst_mid_fresh: bad byte %0d done %0d expected -1/1", first_bad(), done_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            new_fields();
            run_frame(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 2, -1, 1'b0);
            build_exp();
            n_tests++;
            if (kick_cyc != 1) begin n_fail++; $display("FAIL b2b%0d_accept: kick at cycle %0d expected 1", k, kick_cyc); end
            n_tests++;
            if (first_bad() != -1 || done_cnt != 1 || stall_bad != 0) begin
                n_fail++; $display("FAIL b2b%0d_frame: bad byte %0d done %0d stall_bad %0d expected -1/1/0", k, first_bad(), done_cnt, stall_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_order();
        test_backpressure();
        test_timeout();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
